// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, 8N1 framing constants,
// and the baud divisor helper used by both transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    START_BIT     = 3'd1,
    DATA_TRANSFER = 3'd2,
    STOP_BIT      = 3'd3,
    DONE          = 3'd4
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 while not cleared,
// pulsing bit_end on the terminal count and restarting from zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register so the host
// can queue the next byte while the current frame is on the line.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int FREQ      = 24_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] DATA_byte,
  output logic       tx_ready,
  output logic       DATA_serial,
  output logic       busy,
  output logic       done_tick
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQ, BAUD_RATE);

  uart_state_t state;
  logic [7:0]  hold_byte;
  logic        hold_full;
  logic [7:0]  shift;
  logic [2:0]  index;
  logic        bit_end;
  logic        timer_clear;
  logic        accept;
  logic        load;

  assign tx_ready = ~hold_full;
  assign accept   = tx_valid & ~hold_full;
  assign load     = (state == IDLE) & hold_full;

  assign timer_clear = !(state == START_BIT ||
                         state == DATA_TRANSFER ||
                         state == STOP_BIT);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_byte <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold_byte <= DATA_byte;
      hold_full <= accept | (hold_full & ~load);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      index       <= '0;
      DATA_serial <= 1'b1;
      busy        <= 1'b0;
      done_tick   <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          DATA_serial <= 1'b1;
          busy        <= 1'b0;
          if (hold_full) begin
            shift       <= hold_byte;
            index       <= '0;
            state       <= START_BIT;
            DATA_serial <= 1'b0;
            busy        <= 1'b1;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            state       <= DATA_TRANSFER;
            index       <= '0;
            DATA_serial <= shift[0];
          end
        end
        DATA_TRANSFER: begin
          if (bit_end) begin
            if (index == 3'd7) begin
              state       <= STOP_BIT;
              DATA_serial <= 1'b1;
            end else begin
              index       <= index + 3'd1;
              shift       <= shift >> 1;
              DATA_serial <= shift[1];
            end
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            state     <= DONE;
            done_tick <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          DATA_serial <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          DATA_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame tables, queueing
// corner cases, random traffic, and a full-rate loopback decode.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] DATA_byte;
  logic       tx_ready;
  logic       DATA_serial;
  logic       busy;
  logic       done_tick;

  logic       tx_valid2;
  logic [7:0] data2;
  logic       tx_ready2;
  logic       line2;
  logic       busy2;
  logic       done2;

  always #5 clk = ~clk;

  uart_transmitter #(.FREQ(16), .BAUD_RATE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .DATA_byte  (DATA_byte),
    .tx_ready   (tx_ready),
    .DATA_serial(DATA_serial),
    .busy       (busy),
    .done_tick  (done_tick)
  );

  uart_transmitter dut2 (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid2),
    .DATA_byte  (data2),
    .tx_ready   (tx_ready2),
    .DATA_serial(line2),
    .busy       (busy2),
    .done_tick  (done2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_tick === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference receiver: mid-bit sampling of the 16-cycle line
  bit         mon_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  always begin : monitor
    logic [7:0] b;
    logic       ok;
    @(negedge clk);
    if (mon_en && reset === 1'b0 && DATA_serial === 1'b0) begin
      start_q.push_back(cyc);
      ok = 1'b1;
      b  = '0;
      repeat (8) @(negedge clk);
      if (DATA_serial !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = DATA_serial;
      end
      repeat (16) @(negedge clk);
      if (DATA_serial !== 1'b1) ok = 1'b0;
      chk("mon_framing", {31'd0, ok}, 32'd1);
      rx_q.push_back(b);
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    int   n;
    logic r;
    n = 0;
    acc = -1;
    tx_valid = 1'b1;
    DATA_byte = b;
    while (1) begin
      r = tx_ready;
      @(negedge clk);
      if (r === 1'b1) begin
        acc = cyc;
        exp_q.push_back(b);
        break;
      end
      n++;
      if (n > 400) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < n * 200 + 400) begin
      @(negedge clk);
      t++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic compare_q(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk(name, rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   acc1, acc2, acc3, base, t0, n;
    logic ok;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    reset = 1'b1;
    tx_valid = 1'b0;
    DATA_byte = '0;
    tx_valid2 = 1'b0;
    data2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", DATA_serial, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_tick, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of data bit 1 of 0xA5 (a low bit)
    tx_valid = 1'b1;
    DATA_byte = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (38) @(negedge clk);
    chk("t1_line_low", DATA_serial, 0);
    chk("t1_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("t1_rst_line", DATA_serial, 1);
    chk("t1_rst_ready", tx_ready, 1);
    chk("t1_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    base = done_cnt;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (DATA_serial !== 1'b1) ok = 1'b0;
    end
    chk("t1_no_done", done_cnt - base, 0);
    chk("t1_line_idle", {31'd0, ok}, 1);

    // Table-driven single frames, cycle-exact
    for (int v = 0; v < 5; v++) begin
      base = done_cnt;
      tx_valid = 1'b1;
      DATA_byte = vecs[v].data;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tbl_ready_low", tx_ready, 0);
      chk("tbl_still_idle", DATA_serial, 1);
      @(negedge clk);
      chk("tbl_busy_start", busy, 1);
      chk("tbl_ready_back", tx_ready, 1);
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < 16; c++) begin
          if (DATA_serial !== vecs[v].frame[k]) ok = 1'b0;
          @(negedge clk);
        end
      end
      chk("tbl_frame", {31'd0, ok}, 1);
      chk("tbl_done_hi", done_tick, 1);
      chk("tbl_busy_done", busy, 1);
      chk("tbl_line_done", DATA_serial, 1);
      @(negedge clk);
      chk("tbl_done_lo", done_tick, 0);
      chk("tbl_busy_idle", busy, 0);
      chk("tbl_done_cnt", done_cnt - base, 1);
    end

    // Back-to-back with tx_valid held
    mon_en = 1'b1;
    base = done_cnt;
    send(8'h00, acc1);
    send(8'hFF, acc2);
    tx_valid = 1'b0;
    chk("t3_accept_gap", acc2 - acc1, 2);
    wait_rx(2);
    if (start_q.size() >= 2)
      chk("t3_start_gap", start_q[1] - start_q[0], 162);
    repeat (12) @(negedge clk);
    chk("t3_done_cnt", done_cnt - base, 2);
    compare_q("t3_data");

    // Offer while holding register is full must be ignored
    send(8'h11, acc1);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h22, acc2);
    tx_valid = 1'b1;
    DATA_byte = 8'h3C;
    ok = 1'b1;
    repeat (50) begin
      if (tx_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("t4_ready_low", {31'd0, ok}, 1);
    wait_rx(2);
    repeat (12) @(negedge clk);
    chk("t4_rx_size", rx_q.size(), 2);
    compare_q("t4_data");

    // Three queued bytes: load and next accept interleave
    send(8'h33, acc1);
    send(8'h44, acc2);
    send(8'h55, acc3);
    tx_valid = 1'b0;
    wait_rx(3);
    if (start_q.size() >= 3)
      chk("t5_start_gap", start_q[2] - start_q[1], 162);
    repeat (12) @(negedge clk);
    chk("t5_rx_size", rx_q.size(), 3);
    compare_q("t5_data");

    // Random traffic with random gaps
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom_range(0, 255)), acc1);
      if ($urandom_range(0, 1) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 200)) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    wait_rx(20);
    repeat (12) @(negedge clk);
    chk("rnd_rx_size", rx_q.size(), 20);
    compare_q("rnd_data");
    mon_en = 1'b0;

    // Default rate: 2500-cycle bits, decoded by a plain receiver
    tx_valid2 = 1'b1;
    data2 = 8'h5A;
    @(negedge clk);
    tx_valid2 = 1'b0;
    n = 0;
    while (line2 !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_start_latency", n, 1);
    t0 = cyc;
    b = '0;
    repeat (1250) @(negedge clk);
    chk("t6_start_mid", line2, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (2500) @(negedge clk);
      b[i] = line2;
    end
    repeat (2500) @(negedge clk);
    chk("t6_stop_mid", line2, 1);
    chk("t6_byte", b, 8'h5A);
    n = 0;
    while (done2 !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done_time", cyc - t0, 25000);
    @(negedge clk);
    chk("t6_done_pulse", done2, 0);
    chk("t6_busy_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
